eth_frame_pattern_matcher: RTL and testbench

Passive multi-pattern frame matcher that snoops one TEMAC AXI4-Stream receive channel (8-bit, no backpressure). It compares each frame's first C_PATTERN_LEN bytes against C_NUM_PATTERNS independently masked patterns. At end of frame it emits one timestamped detection record holding the per-pattern match vector and the frame length. It generalises the fixed two-interface detector in pattern count, pattern length and masking, and adds a bad-frame filter, an enable gate, record handshaking and a drop counter.

---
 rtl/eth_frame_pattern_matcher.sv | 183 ++++++++++++++++++
 tb/tb_eth_frame_pattern_matcher.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_pattern_matcher.sv
// Passive multi-pattern matcher on a TEMAC AXI4-Stream receive channel: masked compare of each
// frame's leading bytes against several patterns, emitting one timestamped record per matching frame.
module eth_frame_pattern_matcher #(
  parameter int C_NUM_PATTERNS = 4,
  parameter int C_PATTERN_LEN  = 64,
  localparam int PW = (C_NUM_PATTERNS > 1) ? $clog2(C_NUM_PATTERNS) : 1,
  localparam int AW = $clog2(C_PATTERN_LEN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      cfg_we,
  input  logic [PW-1:0]             cfg_pattern,
  input  logic [AW-1:0]             cfg_index,
  input  logic [7:0]                cfg_data,
  input  logic [7:0]                cfg_mask,
  input  logic [C_NUM_PATTERNS-1:0] pattern_en,
  input  logic [7:0]                s_axis_tdata,
  input  logic                      s_axis_tuser,
  input  logic                      s_axis_tlast,
  input  logic                      s_axis_tvalid,
  input  logic [63:0]               current_time,
  output logic                      det_valid,
  input  logic                      det_ready,
  output logic [C_NUM_PATTERNS-1:0] det_match,
  output logic [63:0]               det_timestamp,
  output logic [15:0]               det_length,
  output logic [15:0]               det_dropped
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_SKIP} state_t;

  localparam logic [16:0] LEN_LIMIT = 17'(C_PATTERN_LEN);

  logic [7:0] pat_q  [C_NUM_PATTERNS][C_PATTERN_LEN];
  logic [7:0] mask_q [C_NUM_PATTERNS][C_PATTERN_LEN];

  state_t                    state_q, state_d;
  logic [15:0]               len_q, len_d;
  logic [C_NUM_PATTERNS-1:0] work_q, work_d;
  logic [63:0]               ts_q, ts_d;
  logic                      bad_q, bad_d;

  logic                      det_valid_q, det_valid_d;
  logic [C_NUM_PATTERNS-1:0] det_match_q, det_match_d;
  logic [63:0]               det_ts_q, det_ts_d;
  logic [15:0]               det_len_q, det_len_d;
  logic [15:0]               det_drop_q, det_drop_d;

  logic                      in_idle;
  logic [15:0]               beat_off;
  logic [AW-1:0]             beat_idx;
  logic [15:0]               len_new;
  logic                      bad_new;
  logic [C_NUM_PATTERNS-1:0] cmp_fail, short_fail, work_new, match_final;
  logic [63:0]               rec_ts;
  logic                      rec_pend;

  // Per-beat datapath: the byte offset of the current beat equals the bytes already counted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    in_idle  = (state_q == S_IDLE);
    beat_off = in_idle ? 16'd0 : len_q;
    beat_idx = beat_off[AW-1:0];
    len_new  = in_idle ? 16'd1 : ((len_q == 16'hFFFF) ? len_q : len_q + 16'd1);
    bad_new  = (in_idle ? 1'b0 : bad_q) | s_axis_tuser;
    rec_ts   = in_idle ? current_time : ts_q;
    for (int p = 0; p < C_NUM_PATTERNS; p++) begin
      cmp_fail[p] = ({1'b0, beat_off} < LEN_LIMIT) &&
                    (((s_axis_tdata ^ pat_q[p][beat_idx]) & mask_q[p][beat_idx]) != 8'h00);
      // A masked byte the frame never reached counts as a mismatch.
      short_fail[p] = 1'b0;
      for (int i = 0; i < C_PATTERN_LEN; i++) begin
        if ((mask_q[p][i] != 8'h00) && (16'(i) >= len_new)) short_fail[p] = 1'b1;
      end
    end
    work_new    = (in_idle ? pattern_en : work_q) & ~cmp_fail;
    match_final = work_new & ~short_fail;
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    work_d   = work_q;
    ts_d     = ts_q;
    bad_d    = bad_q;
    rec_pend = 1'b0;
    if (s_axis_tvalid) begin
      unique case (state_q)
        S_IDLE: begin
          if (enable) begin
            ts_d   = current_time;
            len_d  = len_new;
            work_d = work_new;
            bad_d  = bad_new;
            if (s_axis_tlast) rec_pend = !bad_new && (match_final != '0);
            else              state_d  = S_ACTIVE;
          end else if (!s_axis_tlast) begin
            state_d = S_SKIP;
          end
        end
        S_ACTIVE: begin
          len_d  = len_new;
          work_d = work_new;
          bad_d  = bad_new;
          if (s_axis_tlast) begin
            rec_pend = !bad_new && (match_final != '0);
            state_d  = S_IDLE;
          end
        end
        S_SKIP: if (s_axis_tlast) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Single-entry record register; a handshake in the same cycle frees the slot for the new record.
  always_comb begin
    det_valid_d = det_valid_q;
    det_match_d = det_match_q;
    det_ts_d    = det_ts_q;
    det_len_d   = det_len_q;
    det_drop_d  = det_drop_q;
    if (rec_pend) begin
      if (!det_valid_q || det_ready) begin
        det_valid_d = 1'b1;
        det_match_d = match_final;
        det_ts_d    = rec_ts;
        det_len_d   = len_new;
      end else if (det_drop_q != 16'hFFFF) begin
        det_drop_d = det_drop_q + 16'd1;
      end
    end else if (det_valid_q && det_ready) begin
      det_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      work_q      <= '0;
      ts_q        <= '0;
      bad_q       <= 1'b0;
      det_valid_q <= 1'b0;
      det_match_q <= '0;
      det_ts_q    <= '0;
      det_len_q   <= '0;
      det_drop_q  <= '0;
      // NOTE: the pattern store is flop-based and must come out of reset cleared, so it is reset here
      // rather than mapped onto a RAM macro.
      for (int p = 0; p < C_NUM_PATTERNS; p++) begin
        for (int i = 0; i < C_PATTERN_LEN; i++) begin
          pat_q[p][i]  <= 8'h00;
          mask_q[p][i] <= 8'h00;
        end
      end
    end else begin
      // NOTE: all state updates use non-blocking assignment so every flop samples pre-edge values.
      state_q     <= state_d;
      len_q       <= len_d;
      work_q      <= work_d;
      ts_q        <= ts_d;
      bad_q       <= bad_d;
      det_valid_q <= det_valid_d;
      det_match_q <= det_match_d;
      det_ts_q    <= det_ts_d;
      det_len_q   <= det_len_d;
      det_drop_q  <= det_drop_d;
      if (cfg_we && (int'(cfg_pattern) < C_NUM_PATTERNS)) begin
        pat_q[cfg_pattern][cfg_index]  <= cfg_data;
        mask_q[cfg_pattern][cfg_index] <= cfg_mask;
      end
    end
  end

  assign det_valid     = det_valid_q;
  assign det_match     = det_match_q;
  assign det_timestamp = det_ts_q;
  assign det_length    = det_len_q;
  assign det_dropped   = det_drop_q;

endmodule

// File: tb/tb_eth_frame_pattern_matcher.sv
// Directed bench for eth_frame_pattern_matcher: hand-computed records, drops, bad frames,
// enable gating and mid-frame reset.
module tb_eth_frame_pattern_matcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        cfg_we;
  logic [1:0]  cfg_pattern;
  logic [5:0]  cfg_index;
  logic [7:0]  cfg_data;
  logic [7:0]  cfg_mask;
  logic [3:0]  pattern_en;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tuser;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic [63:0] current_time;
  logic        det_valid;
  logic        det_ready;
  logic [3:0]  det_match;
  logic [63:0] det_timestamp;
  logic [15:0] det_length;
  logic [15:0] det_dropped;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] frame_bytes [0:63];

  eth_frame_pattern_matcher #(.C_NUM_PATTERNS(4), .C_PATTERN_LEN(64)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_index(cfg_index),
    .cfg_data(cfg_data), .cfg_mask(cfg_mask), .pattern_en(pattern_en),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .current_time(current_time), .det_valid(det_valid), .det_ready(det_ready),
    .det_match(det_match), .det_timestamp(det_timestamp),
    .det_length(det_length), .det_dropped(det_dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input int p, input int idx, input logic [7:0] data, input logic [7:0] mask);
    cfg_we      = 1'b1;
    cfg_pattern = 2'(p);
    cfg_index   = 6'(idx);
    cfg_data    = data;
    cfg_mask    = mask;
    tick();
    cfg_we      = 1'b0;
  endtask

  task automatic program_head(input int p);
    for (int i = 0; i < 6; i++) cfg_write(p, i, 8'hFF, 8'hFF);
  endtask

  // Broadcast-style frame: six ff bytes then an incrementing filler that never equals 8'h11.
  task automatic build_frame(input logic [7:0] byte40);
    for (int i = 0; i < 64; i++) frame_bytes[i] = (i < 6) ? 8'hFF : 8'(8'h20 + i);
    frame_bytes[40] = byte40;
  endtask

  task automatic send_frame(input int len, input int bad_idx, input logic [63:0] t0,
                            input int en_from, input bit with_last, input bit ready_on_last);
    for (int i = 0; i < len; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = frame_bytes[i];
      s_axis_tuser  = (i == bad_idx);
      s_axis_tlast  = with_last && (i == len - 1);
      current_time  = t0 + 64'(i);
      enable        = (i >= en_from);
      det_ready     = ready_on_last && (i == len - 1);
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    det_ready     = 1'b0;
    enable        = 1'b1;
  endtask

  task automatic consume();
    det_ready = 1'b1;
    tick();
    det_ready = 1'b0;
    check("consume_clears_valid", 64'(det_valid), 64'd0);
  endtask

  initial begin
    enable = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_index = '0; cfg_data = '0; cfg_mask = '0;
    pattern_en = 4'b0000; s_axis_tdata = '0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b0; current_time = '0; det_ready = 1'b0;
    do_reset();

    check("rst_valid",     64'(det_valid),   64'd0);
    check("rst_match",     64'(det_match),   64'd0);
    check("rst_timestamp", det_timestamp,    64'd0);
    check("rst_length",    64'(det_length),  64'd0);
    check("rst_dropped",   64'(det_dropped), 64'd0);

    // Basic 64-byte match on pattern 0.
    program_head(0);
    pattern_en = 4'b0001;
    build_frame(8'h00);
    send_frame(64, -1, 64'd1000, 0, 1'b1, 1'b0);
    check("basic_valid",     64'(det_valid),  64'd1);
    check("basic_match",     64'(det_match),  64'h1);
    check("basic_timestamp", det_timestamp,   64'd1000);
    check("basic_length",    64'(det_length), 64'd64);
    consume();

    // Same frame flagged bad mid-frame, then bad only on the tlast beat.
    send_frame(64, 10, 64'd1100, 0, 1'b1, 1'b0);
    check("bad_mid_valid",   64'(det_valid),   64'd0);
    check("bad_mid_dropped", 64'(det_dropped), 64'd0);
    send_frame(64, 63, 64'd1200, 0, 1'b1, 1'b0);
    check("bad_last_valid",  64'(det_valid),   64'd0);

    // Pattern 1 needs byte 40; a 30-byte frame is too short to satisfy it.
    program_head(1);
    cfg_write(1, 40, 8'h11, 8'hFF);
    pattern_en = 4'b0010;
    send_frame(30, -1, 64'd1300, 0, 1'b1, 1'b0);
    check("short_valid", 64'(det_valid), 64'd0);
    send_frame(64, -1, 64'd1400, 0, 1'b1, 1'b0);
    check("p1_byte40_wrong_valid", 64'(det_valid), 64'd0);
    build_frame(8'h11);
    send_frame(64, -1, 64'd1500, 0, 1'b1, 1'b0);
    check("p1_valid", 64'(det_valid), 64'd1);
    check("p1_match", 64'(det_match), 64'h2);
    consume();

    // Back-to-back records with the consumer stalled: the second is dropped.
    pattern_en = 4'b0001;
    build_frame(8'h00);
    send_frame(64, -1, 64'd2000, 0, 1'b1, 1'b0);
    send_frame(20, -1, 64'd3000, 0, 1'b1, 1'b0);
    check("drop_valid",     64'(det_valid),   64'd1);
    check("drop_held_ts",   det_timestamp,    64'd2000);
    check("drop_held_len",  64'(det_length),  64'd64);
    check("drop_count",     64'(det_dropped), 64'd1);
    // Third record lands in the handshake cycle: it loads, nothing dropped.
    send_frame(10, -1, 64'd4000, 0, 1'b1, 1'b1);
    check("swap_valid",   64'(det_valid),   64'd1);
    check("swap_ts",      det_timestamp,    64'd4000);
    check("swap_len",     64'(det_length),  64'd10);
    check("swap_dropped", 64'(det_dropped), 64'd1);
    consume();

    // enable low at frame start, raised mid-frame: the frame is skipped.
    send_frame(64, -1, 64'd5000, 5, 1'b1, 1'b0);
    check("skip_valid", 64'(det_valid), 64'd0);
    send_frame(12, -1, 64'd5100, 0, 1'b1, 1'b0);
    check("after_skip_valid", 64'(det_valid),  64'd1);
    check("after_skip_len",   64'(det_length), 64'd12);
    check("after_skip_ts",    det_timestamp,   64'd5100);
    consume();

    // Single-beat frame completes in its own cycle.
    send_frame(1, -1, 64'd5500, 0, 1'b1, 1'b0);
    check("single_beat_valid", 64'(det_valid), 64'd0);

    // Reset after 20 bytes of a frame, reprogram, then a fresh frame.
    send_frame(20, -1, 64'd6000, 0, 1'b0, 1'b0);
    do_reset();
    check("midrst_dropped", 64'(det_dropped), 64'd0);
    program_head(0);
    send_frame(64, -1, 64'd7000, 0, 1'b1, 1'b0);
    check("midrst_valid", 64'(det_valid),  64'd1);
    check("midrst_len",   64'(det_length), 64'd64);
    check("midrst_ts",    det_timestamp,   64'd7000);
    consume();
    tick();
    check("midrst_one_record", 64'(det_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
